id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID->EX pipeline register of the MIPS-lite core. Sits directly downstream of the register file.
//  Captures decoded fields plus register-file read data RD1/RD2 into the EX stage.
//  Detects load-use hazards and inserts LOAD_DELAY bubbles while stalling PC and IF/ID.
//  Tracks late writebacks so operands held in EX never go stale during a memory freeze.
// PARAMETERS
//  CTRL_W      8  width of packed EX/MEM/WB control bundle (opaque, passed through)
//  LOAD_DELAY  1  bubbles inserted per load-use hazard (1..3)
// PORTS
//  clk          in   1       clock, all state on rising edge
//  rst_n        in   1       asynchronous active-low reset
//  id_valid     in   1       ID holds a real instruction
//  id_pc        in   32      PC of ID instruction
//  id_rs        in   5       source register 1 (drives regfile r1)
//  id_rt        in   5       source register 2 (drives regfile r2)
//  id_uses_rs   in   1       instruction reads rs
//  id_uses_rt   in   1       instruction reads rt
//  id_dst       in   5       destination register (rd or rt, already selected)
//  id_reg_wen   in   1       instruction writes id_dst
//  id_mem_read  in   1       instruction is a load
//  id_imm       in   32      sign/zero-extended immediate
//  id_rd1       in   32      regfile RD1 (already bypassed for same-cycle WB)
//  id_rd2       in   32      regfile RD2
//  id_ctrl      in   CTRL_W  remaining control bits
//  wb_wen       in   1       writeback enable (same signal as regfile wen)
//  wb_addr      in   5       writeback register (regfile r3)
//  wb_data      in   32      writeback data (regfile WD)
//  flush        in   1       branch/jump redirect from EX: kill ID instruction
//  mem_stall    in   1       global freeze (multi-cycle memory)
//  hazard_stall out  1       hold PC and IF/ID this cycle
//  ex_valid     out  1       EX holds a real instruction
//  ex_pc, ex_rs, ex_rt, ex_dst, ex_imm, ex_ctrl  out  (as ID)  registered copies
//  ex_reg_wen   out  1       registered id_reg_wen, forced 0 when ex_valid=0
//  ex_mem_read  out  1       registered id_mem_read, forced 0 when ex_valid=0
//  ex_a         out  32      operand A (rs value)
//  ex_b         out  32      operand B (rt value)
// BEHAVIOUR
//  Reset (rst_n=0, async): every ex_* output = 0, ex_valid=0, bubble counter=0, hazard_stall=0.
//  hazard = id_valid & ex_valid & ex_mem_read & ex_reg_wen & ex_dst!=0 &
//           ((id_uses_rs & id_rs==ex_dst) | (id_uses_rt & id_rt==ex_dst)).
//  States: IDLE (cnt==0), BUBBLE (cnt!=0).
//  hazard_stall = !flush & id_valid & (hazard | cnt!=0); combinational, same cycle.
//  Per-edge priority, highest first:
//   1 mem_stall: all ex_* and cnt hold. Writeback tracking still applies. hazard_stall still driven.
//   2 flush: ex_valid<=0, cnt<=0, state->IDLE. ID instruction dropped.
//   3 IDLE & hazard: ex_valid<=0 (bubble), cnt<=LOAD_DELAY-1.
//   4 BUBBLE: ex_valid<=0, cnt<=cnt-1. At cnt==1 the next cycle issues normally.
//   5 else: capture all id_* fields; ex_valid<=id_valid; ex_a<=id_rd1; ex_b<=id_rd2.
//  Single-stage latency: ID values visible on ex_* the cycle after capture.
//  Writeback tracking: on any edge where ex_valid stays 1 and is not overwritten
//   (mem_stall case), if wb_wen & wb_addr!=0:
//   wb_addr==ex_rs -> ex_a<=wb_data; wb_addr==ex_rt -> ex_b<=wb_data.
//   Both match -> both update. Register 0 is never updated.
//  Bubbles: all ex_* data outputs zero, so a bubble can never alias a hazard.
//  LOAD_DELAY=1 gives exactly one bubble. Values outside 1..3 are a synthesis-time error.
//  Reset asserted mid-bubble returns to IDLE with no pending stall.
// TESTING
//  1 Reset: hold rst_n=0 with random inputs -> all ex_* =0, hazard_stall=0.
//    Release rst_n -> first valid ID instruction appears on ex_* next edge.
//  2 Load-use: EX=lw $5 (mem_read,dst=5); ID=add rs=5 -> hazard_stall=1 one cycle, ex_valid=0.
//    Next cycle add issues with ex_a = id_rd1 (bypassed WB value).
//  3 LOAD_DELAY=2, same sequence -> hazard_stall high 2 cycles, 2 bubbles, then issue.
//    ID rs=0 with EX dst=0 load -> no stall.
//  4 Flush during BUBBLE: cnt=1, flush=1 -> next cycle ex_valid=0, cnt=0, hazard_stall=0.
//  5 Freeze tracking: EX holds rs=3, rt=3, ex_a=ex_b=0x11; mem_stall=1;
//    wb_wen=1, addr=3, data=0xDEADBEEF -> ex_a=ex_b=0xDEADBEEF.
//    Same test with addr=0 -> no change.
//  6 mem_stall and flush together -> EX holds (freeze wins); flush honoured the cycle after mem_stall drops.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with load-use bubble insertion and writeback tracking
// for operands held in EX while the pipeline is frozen by a multi-cycle memory access.
module id_ex_stage #(
  parameter int CTRL_W     = 8,
  parameter int LOAD_DELAY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [31:0]       id_pc,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [4:0]        id_dst,
  input  logic              id_reg_wen,
  input  logic              id_mem_read,
  input  logic [31:0]       id_imm,
  input  logic [31:0]       id_rd1,
  input  logic [31:0]       id_rd2,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              wb_wen,
  input  logic [4:0]        wb_addr,
  input  logic [31:0]       wb_data,
  input  logic              flush,
  input  logic              mem_stall,
  output logic              hazard_stall,
  output logic              ex_valid,
  output logic [31:0]       ex_pc,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_dst,
  output logic [31:0]       ex_imm,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              ex_reg_wen,
  output logic              ex_mem_read,
  output logic [31:0]       ex_a,
  output logic [31:0]       ex_b,
  output logic              dbg_state,
  output logic [1:0]        dbg_cnt
);

  if (LOAD_DELAY < 1 || LOAD_DELAY > 3) begin : g_bad_load_delay
    $error("id_ex_stage: LOAD_DELAY must be in 1..3");
  end

  localparam logic [1:0] INIT_CNT = 2'(LOAD_DELAY - 1);

  typedef enum logic {IDLE = 1'b0, BUBBLE = 1'b1} state_t;

  state_t     state;
  logic [1:0] cnt;
  logic       hazard;
  logic       issue;
  logic       wb_hit;

  assign hazard = id_valid & ex_valid & ex_mem_read & ex_reg_wen & (ex_dst != 5'd0) &
                  ((id_uses_rs & (id_rs == ex_dst)) | (id_uses_rt & (id_rt == ex_dst)));

  assign hazard_stall = !flush & id_valid & (hazard | (cnt != 2'd0));

  // A real capture happens only when nothing above it in priority claims the edge.
  assign issue  = !flush && (state == IDLE) && !hazard;
  assign wb_hit = ex_valid & wb_wen & (wb_addr != 5'd0);

  assign dbg_state = (state == BUBBLE);
  assign dbg_cnt   = cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= 2'd0;
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_rs       <= '0;
      ex_rt       <= '0;
      ex_dst      <= '0;
      ex_imm      <= '0;
      ex_ctrl     <= '0;
      ex_reg_wen  <= 1'b0;
      ex_mem_read <= 1'b0;
      ex_a        <= '0;
      ex_b        <= '0;
    end else if (mem_stall) begin
      // Frozen EX still observes writebacks so its operands never go stale.
      if (wb_hit && (wb_addr == ex_rs)) ex_a <= wb_data;
      if (wb_hit && (wb_addr == ex_rt)) ex_b <= wb_data;
    end else begin
      if (flush) begin
        state <= IDLE;
        cnt   <= 2'd0;
      end else if (state == IDLE && hazard) begin
        state <= (INIT_CNT != 2'd0) ? BUBBLE : IDLE;
        cnt   <= INIT_CNT;
      end else if (state == BUBBLE) begin
        state <= (cnt == 2'd1) ? IDLE : BUBBLE;
        cnt   <= cnt - 2'd1;
      end
      // Bubbles and invalid captures load all-zero fields so they cannot alias a load.
      if (issue && id_valid) begin
        ex_valid    <= 1'b1;
        ex_pc       <= id_pc;
        ex_rs       <= id_rs;
        ex_rt       <= id_rt;
        ex_dst      <= id_dst;
        ex_imm      <= id_imm;
        ex_ctrl     <= id_ctrl;
        ex_reg_wen  <= id_reg_wen;
        ex_mem_read <= id_mem_read;
        ex_a        <= id_rd1;
        ex_b        <= id_rd2;
      end else begin
        ex_valid    <= 1'b0;
        ex_pc       <= '0;
        ex_rs       <= '0;
        ex_rt       <= '0;
        ex_dst      <= '0;
        ex_imm      <= '0;
        ex_ctrl     <= '0;
        ex_reg_wen  <= 1'b0;
        ex_mem_read <= 1'b0;
        ex_a        <= '0;
        ex_b        <= '0;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: two instances (LOAD_DELAY 1 and 2) share stimulus and are
// compared every cycle against a transaction-level model, plus literal spot checks.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_valid, id_uses_rs, id_uses_rt, id_reg_wen, id_mem_read;
  logic [31:0] id_pc, id_imm, id_rd1, id_rd2, wb_data;
  logic [4:0]  id_rs, id_rt, id_dst, wb_addr;
  logic [7:0]  id_ctrl;
  logic        wb_wen, flush, mem_stall;

  logic        hs [2];
  logic        ev [2];
  logic        rw [2];
  logic        mr [2];
  logic        st [2];
  logic [1:0]  cn [2];
  logic [31:0] pc [2];
  logic [31:0] im [2];
  logic [31:0] a  [2];
  logic [31:0] b  [2];
  logic [4:0]  rs [2];
  logic [4:0]  rt [2];
  logic [4:0]  ds [2];
  logic [7:0]  ct [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    id_ex_stage #(.CTRL_W(8), .LOAD_DELAY(g + 1)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc), .id_rs(id_rs),
      .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dst(id_dst),
      .id_reg_wen(id_reg_wen), .id_mem_read(id_mem_read), .id_imm(id_imm),
      .id_rd1(id_rd1), .id_rd2(id_rd2), .id_ctrl(id_ctrl), .wb_wen(wb_wen),
      .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush), .mem_stall(mem_stall),
      .hazard_stall(hs[g]), .ex_valid(ev[g]), .ex_pc(pc[g]), .ex_rs(rs[g]), .ex_rt(rt[g]),
      .ex_dst(ds[g]), .ex_imm(im[g]), .ex_ctrl(ct[g]), .ex_reg_wen(rw[g]),
      .ex_mem_read(mr[g]), .ex_a(a[g]), .ex_b(b[g]), .dbg_state(st[g]), .dbg_cnt(cn[g])
    );
  end

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic        v;
    logic [31:0] pc;
    logic [4:0]  rs, rt, dst;
    logic [31:0] imm;
    logic [7:0]  ctrl;
    logic        wen, mr;
    logic [31:0] a, b;
  } ex_t;

  ex_t m [2];
  int  left [2];   // bubbles still owed after the current one

  function automatic logic load_use(input ex_t e);
    return id_valid && e.v && e.mr && e.wen && e.dst != 0 &&
           ((id_uses_rs && id_rs == e.dst) || (id_uses_rt && id_rt == e.dst));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m[i] <= '0;
        left[i] <= 0;
      end else if (mem_stall) begin
        if (m[i].v && wb_wen && wb_addr != 0) begin
          if (wb_addr == m[i].rs) m[i].a <= wb_data;
          if (wb_addr == m[i].rt) m[i].b <= wb_data;
        end
      end else if (flush) begin
        m[i] <= '0;
        left[i] <= 0;
      end else if (left[i] > 0) begin
        m[i] <= '0;
        left[i] <= left[i] - 1;
      end else if (load_use(m[i])) begin
        m[i] <= '0;
        left[i] <= i;          // LOAD_DELAY-1 with LOAD_DELAY = i+1
      end else if (id_valid) begin
        m[i] <= '{v: 1'b1, pc: id_pc, rs: id_rs, rt: id_rt, dst: id_dst, imm: id_imm,
                  ctrl: id_ctrl, wen: id_reg_wen, mr: id_mem_read, a: id_rd1, b: id_rd2};
      end else begin
        m[i] <= '0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic exp_hs;
      exp_hs = !flush && id_valid && (load_use(m[i]) || left[i] > 0);
      chk($sformatf("d%0d_hazard_stall", i), 32'(hs[i]), 32'(exp_hs));
      chk($sformatf("d%0d_ex_valid", i), 32'(ev[i]), 32'(m[i].v));
      chk($sformatf("d%0d_ex_pc", i), pc[i], m[i].pc);
      chk($sformatf("d%0d_ex_rs_rt_dst", i), 32'({rs[i], rt[i], ds[i]}),
          32'({m[i].rs, m[i].rt, m[i].dst}));
      chk($sformatf("d%0d_ex_imm", i), im[i], m[i].imm);
      chk($sformatf("d%0d_ex_ctrl_wen_mr", i), 32'({ct[i], rw[i], mr[i]}),
          32'({m[i].ctrl, m[i].wen, m[i].mr}));
      chk($sformatf("d%0d_ex_a", i), a[i], m[i].a);
      chk($sformatf("d%0d_ex_b", i), b[i], m[i].b);
      chk($sformatf("d%0d_cnt", i), 32'(cn[i]), 32'(left[i]));
      chk($sformatf("d%0d_state", i), 32'(st[i]), 32'(left[i] != 0));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [31:0] p, input logic [4:0] s, t,
                        input logic us, ut, input logic [4:0] d, input logic w, ld,
                        input logic [31:0] r1, r2);
    id_valid = v; id_pc = p; id_rs = s; id_rt = t; id_uses_rs = us; id_uses_rt = ut;
    id_dst = d; id_reg_wen = w; id_mem_read = ld; id_rd1 = r1; id_rd2 = r2;
    id_imm = p + 32'h1000; id_ctrl = p[9:2];
  endtask

  task automatic randomize_inputs();
    set_id(1'($urandom), $urandom, 5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom),
           5'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom);
    wb_wen = 1'($urandom); wb_addr = 5'($urandom); wb_data = $urandom;
    flush = 1'($urandom); mem_stall = 1'($urandom);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    randomize_inputs();
    for (int k = 0; k < 4; k++) begin
      step();
      randomize_inputs();
    end
    chk("rst_ex_valid", 32'(ev[0]), 32'h0);
    chk("rst_ex_a", a[1], 32'h0);
    chk("rst_ex_pc", pc[0], 32'h0);

    rst_n = 1'b1;
    wb_wen = 0; wb_addr = 0; wb_data = 0; flush = 0; mem_stall = 0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rst_hazard_stall", 32'(hs[0]), 32'h0);
    step();

    // first instruction after reset
    set_id(1, 32'h100, 1, 2, 1, 1, 3, 1, 0, 32'hA, 32'hB);
    step();
    chk("first_ex_valid", 32'(ev[0]), 32'h1);
    chk("first_ex_pc", pc[1], 32'h100);

    // load-use: lw $5 then add rs=5
    set_id(1, 32'h104, 1, 0, 1, 0, 5, 1, 1, 32'h40, 0);
    step();
    set_id(1, 32'h108, 5, 2, 1, 1, 6, 1, 0, 32'h55, 32'h66);
    #1;
    chk("lu_stall_d1", 32'(hs[0]), 32'h1);
    chk("lu_stall_d2", 32'(hs[1]), 32'h1);
    step();
    chk("lu_bubble_valid_d1", 32'(ev[0]), 32'h0);
    chk("lu_bubble_a_d1", a[0], 32'h0);
    chk("lu_after_stall_d1", 32'(hs[0]), 32'h0);
    chk("lu_still_stall_d2", 32'(hs[1]), 32'h1);
    chk("lu_cnt_d2", 32'(cn[1]), 32'h1);
    step();
    chk("lu_issue_valid_d1", 32'(ev[0]), 32'h1);
    chk("lu_issue_a_d1", a[0], 32'h55);
    chk("lu_bubble2_valid_d2", 32'(ev[1]), 32'h0);
    chk("lu_release_d2", 32'(hs[1]), 32'h0);
    step();
    chk("lu_issue_a_d2", a[1], 32'h55);

    // load to $0 never stalls
    set_id(1, 32'h200, 1, 0, 1, 0, 0, 1, 1, 0, 0);
    step();
    set_id(1, 32'h204, 0, 0, 1, 1, 8, 1, 0, 32'h7, 32'h8);
    #1;
    chk("zero_dst_d1", 32'(hs[0]), 32'h0);
    chk("zero_dst_d2", 32'(hs[1]), 32'h0);
    step();

    // flush while in BUBBLE
    set_id(1, 32'h400, 1, 0, 1, 0, 7, 1, 1, 0, 0);
    step();
    set_id(1, 32'h404, 7, 0, 1, 0, 9, 1, 0, 32'h77, 0);
    step();
    flush = 1;
    #1;
    chk("fl_gate_stall_d2", 32'(hs[1]), 32'h0);
    chk("fl_cnt_before_d2", 32'(cn[1]), 32'h1);
    step();
    flush = 0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("fl_valid_d2", 32'(ev[1]), 32'h0);
    chk("fl_cnt_d2", 32'(cn[1]), 32'h0);
    set_id(1, 32'h408, 7, 0, 1, 0, 9, 1, 0, 0, 0);
    #1;
    chk("fl_no_stall_d2", 32'(hs[1]), 32'h0);
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();

    // writeback tracking during a freeze
    set_id(1, 32'h300, 3, 3, 1, 1, 9, 1, 0, 32'h11, 32'h11);
    step();
    chk("fz_a_init", a[0], 32'h11);
    mem_stall = 1; wb_wen = 1; wb_addr = 3; wb_data = 32'hDEADBEEF;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    chk("fz_a_d1", a[0], 32'hDEADBEEF);
    chk("fz_b_d1", b[0], 32'hDEADBEEF);
    chk("fz_a_d2", a[1], 32'hDEADBEEF);
    chk("fz_b_d2", b[1], 32'hDEADBEEF);
    wb_addr = 0; wb_data = 32'h12345678;
    step();
    chk("fz_r0_a", a[0], 32'hDEADBEEF);
    chk("fz_r0_b", b[1], 32'hDEADBEEF);

    // freeze beats flush, flush honoured once freeze drops
    wb_wen = 0; flush = 1;
    set_id(1, 32'h500, 1, 2, 1, 1, 4, 1, 0, 1, 2);
    step();
    chk("fzfl_hold_valid", 32'(ev[0]), 32'h1);
    chk("fzfl_hold_pc", pc[0], 32'h300);
    mem_stall = 0;
    step();
    chk("fzfl_flush_valid", 32'(ev[0]), 32'h0);
    chk("fzfl_flush_pc", pc[1], 32'h0);
    flush = 0;

    // back-to-back loads and consumers with writeback traffic and short freezes
    for (int k = 0; k < 12; k++) begin
      set_id(1, 32'h600 + 32'(k * 4), 5'(k % 4 + 1), 5'(k % 3 + 2), 1, k[0],
             5'(k % 4 + 2), 1, (k % 3 == 0), 32'(k * 17), 32'(k * 31));
      wb_wen = k[1]; wb_addr = 5'(k % 5); wb_data = 32'hC0DE0000 + 32'(k);
      mem_stall = (k % 5 == 4);
      step();
    end
    mem_stall = 0; wb_wen = 0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
